fetch_stage: RTL and testbench

Instruction-fetch front end of the core: owns the program counter, drives the word address into the combinational instruction memory, captures the returned instruction together with its PC into a small in-order fetch queue, and presents entries to decode over a valid/ready handshake. Redirects from execute (branches and jumps) flush the queue and reload the PC. This decouples decode stalls from fetch so that instruction memory is read at most once per cycle.

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths, fetch queue entry type and reset PC
package core_pkg;

  localparam int INST_W  = 32;
  localparam int XLEN    = 32;
  localparam int ENTRY_W = XLEN + INST_W;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - QDEPTH-entry in-order FIFO of fetch entries with flush
module fetch_queue
  import core_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(QDEPTH);

  logic [ENTRY_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W:0]     count;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail] <= wr_data;
    end
  end

  // Pointers wrap for free because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[head];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, redirect and fetch queue front end; FETCH_MISALIGN_TRAP_EN enables misaligned-redirect fault
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault_valid,
  output logic [31:0] fault_pc
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  fetch_entry_t    wr_entry;
  fetch_entry_t    rd_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            fault_q;
  logic [XLEN-1:0] fault_pc_q;

  // Every redirect re-evaluates the fault, so an aligned one clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (redirect_valid) begin
      fault_q <= |redirect_pc[1:0];
      if (|redirect_pc[1:0]) fault_pc_q <= redirect_pc;
    end
  end

  assign target      = redirect_pc;
  assign fault_valid = fault_q;
  assign fault_pc    = fault_pc_q;
`else
  assign target      = redirect_pc & ~XLEN'(3);
  assign fault_valid = 1'b0;
  assign fault_pc    = '0;
`endif

  assign out_valid = !empty && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = fetch_en && !redirect_valid && !fault_valid && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= target;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  assign imem_addr = pc;
  assign wr_entry  = '{pc: pc, inst: imem_inst};

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wr_data(wr_entry),
    .rd_data(rd_entry),
    .full   (full),
    .empty  (empty)
  );

  assign out_inst = rd_entry.inst;
  assign out_pc   = rd_entry.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with queue-based reference model
module tb_fetch_stage;

  localparam int          QD   = 2;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fault_valid;
  logic [31:0] fault_pc;

  int n_pass  = 0;
  int n_total = 0;

  fetch_stage #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .fault_valid   (fault_valid),
    .fault_pc      (fault_pc)
  );

  always #5 clk = ~clk;

  // Memory returns its own address as the instruction word.
  assign imem_inst = imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of fetched PCs plus the architectural PC.
  logic [31:0] mq[$];
  logic [31:0] m_pc = RPC;
  logic        m_fault = 1'b0;
  logic [31:0] m_fault_pc = '0;

  always @(negedge clk) begin
    logic exp_valid, m_pop, m_push;
    if (!rst_n) begin
      mq.delete();
      m_pc       = RPC;
      m_fault    = 1'b0;
      m_fault_pc = '0;
      chk("rst_addr", imem_addr, RPC);
      chk("rst_valid", out_valid, 0);
      chk("rst_fault", fault_valid, 0);
      chk("rst_fault_pc", fault_pc, 0);
    end else begin
      exp_valid = (mq.size() != 0) && !redirect_valid;
      chk("m_addr", imem_addr, m_pc);
      chk("m_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("m_pc", out_pc, mq[0]);
        chk("m_inst", out_inst, mq[0]);
      end
      chk("m_fault", fault_valid, m_fault);
      if (m_fault) chk("m_fault_pc", fault_pc, m_fault_pc);
      m_pop  = exp_valid && out_ready;
      m_push = fetch_en && !redirect_valid && !m_fault && ((mq.size() < QD) || m_pop);
      if (redirect_valid) begin
        mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        m_pc    = redirect_pc;
        m_fault = (redirect_pc % 4) != 0;
        if (m_fault) m_fault_pc = redirect_pc;
`else
        m_pc = redirect_pc - (redirect_pc % 4);
`endif
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", out_valid, 0);
    chk("reset_fault_pc", fault_pc, 0);
    repeat (2) cyc();

    // Steady fetch from reset.
    rst_n = 1'b1;
    cyc(); chk("steady0_v", out_valid, 1); chk("steady0_pc", out_pc, 32'h0); chk("steady0_i", out_inst, 32'h0);
    cyc(); chk("steady1_pc", out_pc, 32'h4); chk("steady1_i", out_inst, 32'h4);
    cyc(); chk("steady2_pc", out_pc, 32'h8); chk("steady2_i", out_inst, 32'h8);
    fetch_en = 1'b0;
    cyc(); cyc();
    chk("fetch_off_addr", imem_addr, 32'hc); chk("fetch_off_v", out_valid, 0);

    // Backpressure from a fresh reset.
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("bp_addr", imem_addr, 32'h8); chk("bp_v", out_valid, 1); chk("bp_pc0", out_pc, 32'h0);
    out_ready = 1'b1;
    cyc(); chk("bp_pc4", out_pc, 32'h4); chk("bp_full_addr", imem_addr, 32'hc);
    cyc(); chk("bp_pc8", out_pc, 32'h8);

    // Redirect while full.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1 chk("redir_v", out_valid, 0);
    cyc(); redirect_valid = 1'b0;
    chk("redir_empty", out_valid, 0); chk("redir_addr", imem_addr, 32'h40);
    cyc(); chk("redir_v2", out_valid, 1); chk("redir_pc", out_pc, 32'h40);

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    cyc(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", fault_valid, 1); chk("mis_fault_pc", fault_pc, 32'h42);
    cyc(); chk("mis_halt_v", out_valid, 0); chk("mis_halt_addr", imem_addr, 32'h42);
`else
    chk("mis_addr", imem_addr, 32'h40); chk("mis_fault", fault_valid, 0);
    cyc(); chk("mis_pc", out_pc, 32'h40); chk("mis_v", out_valid, 1);
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cyc(); redirect_valid = 1'b0;
    chk("clr_fault", fault_valid, 0);
    cyc(); chk("clr_pc", out_pc, 32'h80); chk("clr_v", out_valid, 1);
    repeat (2) cyc();

    // Asynchronous reset mid-stream.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk("async_v", out_valid, 0); chk("async_addr", imem_addr, RPC);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); chk("restart_v", out_valid, 1); chk("restart_pc", out_pc, RPC);
    cyc(); chk("restart_pc4", out_pc, RPC + 32'd4);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
